// File: rtl/mult_accumulate_stage_if.sv
// rtl/mult_accumulate_stage_if.sv - operand, multiplier and result handshake bundle for mult_accumulate_stage
interface mult_accumulate_stage_if #(
  parameter int size     = 16,
  parameter int out_size = 16
);
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  mult_enable;
  logic [2*size-1:0]     mult_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [out_size-1:0]   out_data;
  logic                  out_overflow;

  modport master (
    output in_valid, in_last, mult_out, out_ready,
    input  in_ready, mult_enable, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_last, mult_out, out_ready,
    output in_ready, mult_enable, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/mult_accumulate_stage.sv
// rtl/mult_accumulate_stage.sv - dot-product accumulator behind a slow multiplier; scaled, saturated result out
// Optional round-half-up scaling enabled by defining MULT_ACC_ROUND_EN.
module mult_accumulate_stage #(
  parameter int size       = 16,
  parameter int acc_size   = 40,
  parameter int frac_shift = 8,
  parameter int out_size   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_accumulate_stage_if.slave bus
);
  localparam int wide = acc_size + 1;
  localparam int rnd_pos = (frac_shift > 0) ? frac_shift - 1 : 0;
  localparam logic [wide-1:0] out_max  = {{(wide-out_size){1'b0}}, {out_size{1'b1}}};
  localparam logic [wide-1:0] rnd_bias = (frac_shift > 0) ? (wide'(1) << rnd_pos) : '0;

  logic [size-1:0]     vld_line;
  logic [size-1:0]     lst_line;
  logic [acc_size-1:0] acc;
  logic                first;
  logic                ovf;
  logic                out_valid_q;
  logic [out_size-1:0] out_data_q;
  logic                out_overflow_q;

  logic                tail_valid;
  logic                tail_last;
  logic                advance;
  logic [acc_size-1:0] acc_base;
  logic [wide-1:0]     sum_wide;
  logic [acc_size-1:0] sum;
  logic                carry;
  logic [wide-1:0]     scaled;
  logic                saturate;

  assign tail_valid = vld_line[size-1];
  assign tail_last  = lst_line[size-1];

  // Only a finished vector meeting a blocked output stalls; depends on registers and out_ready only.
  assign advance = !(out_valid_q && !bus.out_ready && tail_valid && tail_last);

  assign bus.mult_enable  = advance;
  assign bus.in_ready     = advance;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_overflow_q;

  always_comb begin
    acc_base = first ? '0 : acc;
    sum_wide = {1'b0, acc_base} + {{(wide-2*size){1'b0}}, bus.mult_out};
    sum      = sum_wide[acc_size-1:0];
    carry    = sum_wide[acc_size];
`ifdef MULT_ACC_ROUND_EN
    scaled   = ({1'b0, sum} + rnd_bias) >> frac_shift;
`else
    scaled   = {1'b0, sum} >> frac_shift;
`endif
    saturate = (scaled > out_max);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_line       <= '0;
      lst_line       <= '0;
      acc            <= '0;
      first          <= 1'b1;
      ovf            <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (advance) begin
        vld_line <= {vld_line[size-2:0], bus.in_valid};
        lst_line <= {lst_line[size-2:0], bus.in_valid & bus.in_last};
        if (tail_valid) begin
          if (!tail_last) begin
            acc   <= sum;
            first <= 1'b0;
            ovf   <= ovf | carry;
          end else begin
            out_valid_q    <= 1'b1;
            out_data_q     <= saturate ? {out_size{1'b1}} : scaled[out_size-1:0];
            out_overflow_q <= saturate | ovf | carry;
            first          <= 1'b1;
            ovf            <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_accumulate_stage.sv
// tb/tb_mult_accumulate_stage.sv - directed vector bench for mult_accumulate_stage with a behavioural multiplier
module tb_mult_accumulate_stage;
  localparam int SIZE = 16;

`ifdef MULT_ACC_ROUND_EN
  localparam logic [15:0] EXP_RND = 16'h0001;
`else
  localparam logic [15:0] EXP_RND = 16'h0000;
`endif

  typedef struct {
    string           name;
    int              n;
    logic [3:0][15:0] a;
    logic [15:0]     b;
    logic [15:0]     exp_data;
    logic            exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [31:0] pipe [SIZE];
  int          n_vec = 0;
  int          n_err = 0;
  int          lat;
  vec_t        tbl [6];

  mult_accumulate_stage_if #(.size(SIZE), .out_size(16)) bus ();

  mult_accumulate_stage #(
    .size(SIZE), .acc_size(40), .frac_shift(8), .out_size(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: latency of SIZE enabled cycles, frozen with the enable, never reset.
  always_ff @(posedge clk) begin
    if (bus.mult_enable) begin
      pipe[0] <= 32'(a_in) * 32'(b_in);
      for (int i = 1; i < SIZE; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.mult_out = pipe[SIZE-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!bus.out_valid && l < 60) begin
      step();
      l++;
    end
  endtask

  task automatic send(input int n, input logic [3:0][15:0] a, input logic [15:0] b, input logic last_flag);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_last  = last_flag && (i == n - 1);
      a_in = a[i];
      b_in = b;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{"single",     1, {16'h0, 16'h0, 16'h0, 16'h0300},   16'h0200, 16'h0600, 1'b0};
    tbl[1] = '{"dot4",       4, {16'd4, 16'd3, 16'd2, 16'd1},      16'h0100, 16'h000A, 1'b0};
    tbl[2] = '{"max_sq",     1, {16'h0, 16'h0, 16'h0, 16'hFFFF},   16'hFFFF, 16'hFFFF, 1'b1};
    tbl[3] = '{"sum_sat",    2, {16'h0, 16'h0, 16'h8000, 16'h8000}, 16'h0100, 16'hFFFF, 1'b1};
    tbl[4] = '{"exact_max",  1, {16'h0, 16'h0, 16'h0, 16'hFFFF},   16'h0100, 16'hFFFF, 1'b0};
    tbl[5] = '{"round_half", 1, {16'h0, 16'h0, 16'h0, 16'h0001},   16'h0080, EXP_RND,  1'b0};

    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid",    64'(bus.out_valid),    64'd0);
    check("rst_out_data",     64'(bus.out_data),     64'd0);
    check("rst_out_overflow", 64'(bus.out_overflow), 64'd0);
    check("rst_in_ready",     64'(bus.in_ready),     64'd1);
    check("rst_mult_enable",  64'(bus.mult_enable),  64'd1);
    reset = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      send(tbl[v].n, tbl[v].a, tbl[v].b, 1'b1);
      wait_result(lat);
      check({tbl[v].name, "_latency"},  64'(lat),              64'd16);
      check({tbl[v].name, "_data"},     64'(bus.out_data),     64'(tbl[v].exp_data));
      check({tbl[v].name, "_overflow"}, 64'(bus.out_overflow), 64'(tbl[v].exp_ovf));
      step();
      check({tbl[v].name, "_no_dup"},   64'(bus.out_valid),    64'd0);
    end

    // Two single-element results against a blocked output.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b1;
    a_in = 16'h0001;
    b_in = 16'h0100;
    step();
    a_in = 16'h0002;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_result(lat);
    check("bp_latency",     64'(lat),             64'd15);
    check("bp_first_data",  64'(bus.out_data),    64'h0001);
    check("bp_stall_en",    64'(bus.mult_enable), 64'd0);
    check("bp_stall_ready", 64'(bus.in_ready),    64'd0);
    for (int i = 0; i < 3; i++) step();
    check("bp_hold_valid",  64'(bus.out_valid),   64'd1);
    check("bp_hold_data",   64'(bus.out_data),    64'h0001);
    check("bp_hold_en",     64'(bus.mult_enable), 64'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_second_valid", 64'(bus.out_valid),   64'd1);
    check("bp_second_data",  64'(bus.out_data),    64'h0002);
    check("bp_resume_en",    64'(bus.mult_enable), 64'd1);
    step();
    check("bp_no_dup",       64'(bus.out_valid),   64'd0);

    // Partial vector accumulated, more in flight, then reset.
    send(2, {16'h0, 16'h0, 16'h1000, 16'h1000}, 16'h0100, 1'b0);
    for (int i = 0; i < 18; i++) step();
    send(2, {16'h0, 16'h0, 16'h1000, 16'h1000}, 16'h0100, 1'b0);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    step();
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    reset = 1'b1;
    send(1, {16'h0, 16'h0, 16'h0, 16'h0100}, 16'h0100, 1'b1);
    wait_result(lat);
    check("post_rst_latency",  64'(lat),              64'd16);
    check("post_rst_data",     64'(bus.out_data),     64'h0100);
    check("post_rst_overflow", 64'(bus.out_overflow), 64'd0);
    step();
    for (int i = 0; i < 20; i++) step();
    check("post_rst_quiet",    64'(bus.out_valid),    64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
